// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 4-digit display scan controller.
package seg_scan_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

endpackage

// File: rtl/seg_scan_next_idx.sv
// Cyclic search for the next enabled digit strictly after cur_idx.
// With cur_idx=3 the result is the lowest set bit of mask.
module scan_next_idx
   import seg_scan_pkg::*;
(
   input  logic [1:0] cur_idx,
   input  logic [3:0] mask,
   output logic [1:0] next_idx,
   output logic       wrap,
   output logic       none
);

   logic       found;
   logic [1:0] cand;

   always_comb begin
      next_idx = cur_idx;
      found    = 1'b0;
      cand     = cur_idx;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         cand = cur_idx + 2'(k);
         if (!found && mask[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   assign none = (mask == 4'b0000);
   // A single-digit mask lands back on cur_idx, which also counts as a wrap.
   assign wrap = !none && (next_idx <= cur_idx);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller driving a 2-to-4 active-low digit decoder,
// with per-slot blanking, masked-digit skipping and a frame-wrap pulse.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  digit_mask,
   input  logic [15:0] data_in,
   output logic        sel_a,
   output logic        sel_b,
   output logic        dec_en,
   output logic [3:0]  nibble_out,
   output logic        frame_tick
);

   localparam int              CNT_W      = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam state_t          SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   state_t           state, state_n;
   logic [1:0]       idx, idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             kill, kill_n;
   logic [1:0]       sel_n;
   logic [3:0]       nib_n;
   logic             dec_n, frame_n;

   logic [1:0] srch_cur, srch_next;
   logic       srch_wrap, srch_none;

   // From IDLE the search starts "after digit 3" so it returns the lowest set bit.
   assign srch_cur = (state == ST_IDLE) ? 2'd3 : idx;

   scan_next_idx u_next (
      .cur_idx  (srch_cur),
      .mask     (digit_mask),
      .next_idx (srch_next),
      .wrap     (srch_wrap),
      .none     (srch_none)
   );

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt + 1'b1;
      kill_n  = kill | ~digit_mask[idx];
      frame_n = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_n  = '0;
            kill_n = 1'b0;
            if (en && !srch_none) begin
               state_n = SLOT_START;
               idx_n   = srch_next;
            end
         end
         ST_BLANK: begin
            if (cnt == BLANK_LAST) state_n = ST_SHOW;
         end
         ST_SHOW: begin
            if (cnt == CNT_LAST) begin
               cnt_n  = '0;
               kill_n = 1'b0;
               if (srch_none) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = SLOT_START;
                  idx_n   = srch_next;
                  frame_n = srch_wrap;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            kill_n  = 1'b0;
         end
      endcase

      if (state != ST_IDLE && !en) begin
         state_n = ST_IDLE;
         idx_n   = idx;
         cnt_n   = '0;
         kill_n  = 1'b0;
         frame_n = 1'b0;
      end

      // Outputs are registered from next-state values so they line up with the state.
      dec_n = !(state_n == ST_SHOW && !kill_n);
      sel_n = {sel_b, sel_a};
      nib_n = nibble_out;
      if (state_n != ST_IDLE) begin
         sel_n = idx_n;
         nib_n = data_in[{idx_n, 2'b00} +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 2'd0;
         cnt        <= '0;
         kill       <= 1'b0;
         sel_a      <= 1'b0;
         sel_b      <= 1'b0;
         dec_en     <= 1'b1;
         nibble_out <= 4'h0;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         kill       <= kill_n;
         sel_a      <= sel_n[0];
         sel_b      <= sel_n[1];
         dec_en     <= dec_n;
         nibble_out <= nib_n;
         frame_tick <= frame_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic
// against a slot-age reference model.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV = 4;
   localparam int BLANK   = 1;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [3:0]  digit_mask;
   logic [15:0] data_in;
   logic        sel_a, sel_b, dec_en, frame_tick;
   logic [3:0]  nibble_out;

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .digit_mask (digit_mask),
      .data_in    (data_in),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .dec_en     (dec_en),
      .nibble_out (nibble_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: whether a digit is being scanned, which one, and how
   // many cycles have elapsed since its slot began.
   bit         m_run;
   int         m_idx;
   int         m_age;
   bit         m_kill;
   logic [1:0] e_sel;
   logic       e_dec;
   logic [3:0] e_nib;
   logic       e_ft;

   function automatic int lowest_set(logic [3:0] m);
      for (int d = 0; d < 4; d++) if (m[d]) return d;
      return 0;
   endfunction

   function automatic int next_set(int cur, logic [3:0] m);
      for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   task automatic model_edge();
      int nxt;
      if (rst) begin
         m_run = 0; m_idx = 0; m_age = 0; m_kill = 0;
         e_sel = 2'd0; e_dec = 1'b1; e_nib = 4'h0; e_ft = 1'b0;
         return;
      end
      e_ft = 1'b0;
      if (!m_run) begin
         if (en && digit_mask != 4'd0) begin
            m_run = 1; m_idx = lowest_set(digit_mask); m_age = 0; m_kill = 0;
         end
      end else if (!en) begin
         m_run = 0;
      end else if (m_age == CLK_DIV - 1) begin
         if (digit_mask == 4'd0) begin
            m_run = 0;
         end else begin
            nxt    = next_set(m_idx, digit_mask);
            e_ft   = (nxt <= m_idx);
            m_idx  = nxt; m_age = 0; m_kill = 0;
         end
      end else begin
         if (!digit_mask[m_idx]) m_kill = 1;
         m_age++;
      end
      if (m_run) begin
         e_sel = 2'(m_idx);
         e_nib = data_in[m_idx*4 +: 4];
      end
      e_dec = !(m_run && m_age >= BLANK && !m_kill);
   endtask

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("sel",        8'({sel_b, sel_a}), 8'(e_sel));
      check("dec_en",     8'(dec_en),         8'(e_dec));
      check("nibble_out", 8'(nibble_out),     8'(e_nib));
      check("frame_tick", 8'(frame_tick),     8'(e_ft));
   endtask

   task automatic run_until(int want_idx, int want_age);
      int n = 0;
      while (!(m_run && m_idx == want_idx && m_age == want_age) && n < 50) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < 50) else begin
         errors++;
         $error("FAIL wait_slot observed=timeout required=idx%0d_age%0d", want_idx, want_age);
      end
   endtask

   task automatic count_ticks(string tag, int ncyc, int want);
      int ft = 0;
      repeat (ncyc) begin
         cycle();
         ft += int'(frame_tick);
      end
      check(tag, 8'(ft), 8'(want));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; digit_mask = 4'd0; data_in = 16'h0;
      repeat (3) cycle();
      check("reset_dec_en", 8'(dec_en), 8'd1);

      // All four digits
      rst = 1'b0; en = 1'b1; digit_mask = 4'b1111; data_in = 16'hA5C3;
      cycle();
      check("first_blank_nib", 8'(nibble_out), 8'h3);
      repeat (15) cycle();
      count_ticks("ft_period_1111", 32, 2);

      digit_mask = 4'b0101;
      repeat (16) cycle();
      count_ticks("ft_period_0101", 32, 4);

      digit_mask = 4'b1000;
      repeat (8) cycle();
      count_ticks("ft_period_1000", 32, 8);
      check("sel_digit3", 8'({sel_b, sel_a}), 8'd3);

      // Empty mask parks in IDLE; a new bit starts with a blank cycle
      digit_mask = 4'b0000;
      repeat (10) cycle();
      check("idle_dec_en", 8'(dec_en), 8'd1);
      digit_mask = 4'b0010;
      cycle();
      check("restart_blank", 8'(dec_en), 8'd1);
      check("restart_sel", 8'({sel_b, sel_a}), 8'd1);
      cycle();
      check("restart_show", 8'(dec_en), 8'd0);

      // Drop enable in SHOW, then re-enable
      digit_mask = 4'b1111;
      run_until(2, 2);
      en = 1'b0;
      cycle();
      check("en_off_dec", 8'(dec_en), 8'd1);
      check("en_off_sel_hold", 8'({sel_b, sel_a}), 8'd2);
      repeat (3) cycle();
      en = 1'b1;
      cycle();
      check("reen_sel", 8'({sel_b, sel_a}), 8'd0);
      check("reen_blank", 8'(dec_en), 8'd1);

      // Clear the shown digit's mask bit mid-SHOW
      run_until(1, 1);
      digit_mask = 4'b1101;
      cycle();
      check("kill_dec", 8'(dec_en), 8'd1);
      repeat (8) cycle();

      // Reset mid-slot
      digit_mask = 4'b1111;
      run_until(3, 2);
      rst = 1'b1;
      repeat (3) begin
         cycle();
         check("rst_hold_dec", 8'(dec_en), 8'd1);
      end
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         data_in = 16'($urandom);
         if ($urandom_range(0, 15) == 0) digit_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) en = ~en;
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit display; sits directly upstream of the 2-to-4 active-low digit decoder.
- Drives the decoder's select pair (sel_b, sel_a) and its active-high disable (dec_en). Also presents the 4-bit digit code for the selected slot to the segment path.
- Inserts a blanking gap before each digit to prevent ghosting, skips masked digits, and flags each completed frame.

Parameters:
- CLK_DIV, 4: clk cycles per digit slot. Must be >= 2 and >= BLANK_CYCLES+1.
- BLANK_CYCLES, 1: cycles at the start of each slot with dec_en=1. 0 means no blanking.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- digit_mask  in  4  bit i=1 means digit i is scanned.
- data_in  in  16  digit codes; nibble i is data_in[4i+3:4i].
- sel_a  out  1  decoder select LSB (idx[0]).
- sel_b  out  1  decoder select MSB (idx[1]).
- dec_en  out  1  decoder disable. 1 means all digits off; 0 means the selected digit is driven low/on.
- nibble_out  out  4  code of the currently selected digit.
- frame_tick  out  1  one-cycle pulse when the scan wraps to the first digit.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE, idx=0, slot counter=0.
  - sel_a=0, sel_b=0, dec_en=1, nibble_out=0, frame_tick=0.
  - rst has priority over every other input.
  - rst asserted mid-slot forces reset values on the next edge. They are held while rst=1.
- States: IDLE, BLANK, SHOW. The slot counter is $clog2(CLK_DIV) bits wide and is cleared on every slot start.
- IDLE:
  - dec_en=1.
  - If en=1 and digit_mask!=0: idx <= lowest set bit of digit_mask, then go to BLANK. If BLANK_CYCLES=0, go to SHOW instead.
- BLANK:
  - dec_en=1.
  - sel_a/sel_b = idx; nibble_out = data_in nibble[idx] (registered).
  - After BLANK_CYCLES cycles, go to SHOW.
- SHOW:
  - dec_en=0 for CLK_DIV-BLANK_CYCLES cycles.
  - nibble_out tracks data_in nibble[idx] every cycle, with 1-cycle latency.
- Slot boundary (last SHOW cycle):
  - digit_mask is sampled here only.
  - next idx = next set bit strictly after idx, searched cyclically 0..3.
  - If next idx <= current idx (wrap, including the single-digit mask case), frame_tick=1 in the first cycle of the new slot.
  - Then enter BLANK, or SHOW if BLANK_CYCLES=0.
  - If the sampled mask is 0, go to IDLE with dec_en=1 on the next cycle.
- Mask change mid-slot: if digit_mask[idx] goes 0 during BLANK or SHOW, dec_en=1 from the next cycle for the rest of the slot. Slot timing is unchanged.
- en=0 in any non-IDLE state: go to IDLE next cycle, with dec_en=1 and frame_tick=0. sel_a, sel_b and nibble_out hold their values.
- Re-enabling always restarts from the lowest set bit, beginning with BLANK.
- Frame period: CLK_DIV × popcount(digit_mask) cycles.

Decomposition:
- Shared package seg_scan_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BLANK=2'd1, ST_SHOW=2'd2.
  - constant NUM_DIGITS=4.
- One combinational sub-module, scan_next_idx:
  - inputs: cur_idx[1:0], mask[3:0].
  - outputs: next_idx[1:0], wrap, none (mask==0).
  - used both for the next-digit search and, with cur_idx=3, for the lowest-set-bit search.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1):
- rst, then en=1, mask=4'b1111, data_in=16'hA5C3 -> idx sequence 0,1,2,3.
  - Each slot: 1 cycle dec_en=1, then 3 cycles dec_en=0.
  - nibble_out = 3,C,5,A.
  - frame_tick pulses once every 16 cycles, at the start of the idx-0 slot after idx 3.
- mask=4'b0101 -> idx alternates 0,2 (sel_b,sel_a = 00,10); frame_tick every 8 cycles.
- mask=4'b1000 -> idx stays 3 (sel_b=1, sel_a=1); frame_tick every 4 cycles.
- mask=0 with en=1 -> stays IDLE, dec_en=1. Then mask=4'b0010 -> a BLANK cycle, then SHOW with idx=1.
- en dropped during a SHOW cycle -> dec_en=1 next cycle and IDLE. Re-enable with mask=4'b1111 restarts at idx 0 with a BLANK cycle.
- digit_mask[idx] cleared mid-SHOW -> dec_en=1 next cycle until the boundary, then the next set bit is shown.
- rst pulsed mid-slot with en=1 -> next edge: dec_en=1, sel=00, nibble_out=0, frame_tick=0; held while rst=1.
